// File: rtl/expansion_xor_pipe.sv
// Expansion-XOR pipeline: E(R) ^ subkey pushed through an elastic chain of STAGES registers.
// Defining EP_XFER_CNT_EN adds the saturating output transfer counter port xfer_cnt_o.
module expansion_xor_pipe #(
    parameter  int HALF_W = 32,
    parameter  int STAGES = 2,
    localparam int KEY_W  = 3 * HALF_W / 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [HALF_W-1:0] in_r_i,
    input  logic [KEY_W-1:0]  in_key_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [KEY_W-1:0]  out_data_o
`ifdef EP_XFER_CNT_EN
    ,
    output logic [15:0]       xfer_cnt_o
`endif
);

    logic [KEY_W-1:0] expanded;

    // Bit n (1 = MSB) of a vector lives at index WIDTH-n; group g emits R[4g..4g+5] with
    // R[0] and R[HALF_W+1] wrapping to R[HALF_W] and R[1].
    for (genvar gi = 0; gi < HALF_W / 4; gi++) begin : g_grp
        for (genvar bj = 0; bj < 6; bj++) begin : g_bit
            localparam int RAW = 4 * gi + bj;
            localparam int SRC = (RAW == 0) ? HALF_W : ((RAW == HALF_W + 1) ? 1 : RAW);
            assign expanded[KEY_W - 1 - (6 * gi + bj)] = in_r_i[HALF_W - SRC];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stg
        logic             valid_q;
        logic             valid_d;
        logic [KEY_W-1:0] data_q;
        logic [KEY_W-1:0] data_d;
        logic             src_valid;
        logic [KEY_W-1:0] src_data;
        logic             fwd;
        logic             free;

        if (gi == 0) begin : g_src
            assign src_valid = in_valid_i;
            assign src_data  = expanded ^ in_key_i;
        end else begin : g_src
            assign src_valid = g_stg[gi-1].valid_q;
            assign src_data  = g_stg[gi-1].data_q;
        end

        if (gi == STAGES - 1) begin : g_dst
            assign fwd = valid_q && out_ready_i;
        end else begin : g_dst
            assign fwd = valid_q && g_stg[gi+1].free;
        end

        // A stage can take new data if it is empty or its current word leaves this edge.
        assign free = !valid_q || fwd;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (flush_i) begin
                valid_d = 1'b0;
            end else if (free && src_valid) begin
                valid_d = 1'b1;
                data_d  = src_data;
            end else if (fwd) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
    end

    assign in_ready_o  = !flush_i && g_stg[0].free;
    assign out_valid_o = g_stg[STAGES-1].valid_q;
    assign out_data_o  = g_stg[STAGES-1].data_q;

`ifdef EP_XFER_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // A flushed output is dropped and therefore not counted.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_o && out_ready_i && !flush_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_expansion_xor_pipe.sv
// Self-checking bench for expansion_xor_pipe: directed vectors plus random traffic checked
// against a queue-based reference model; a second narrow instance exercises the 8-bit wrap.
module tb_expansion_xor_pipe;
    localparam int HW = 32;
    localparam int KW = 48;
    localparam int ST = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [HW-1:0] in_r;
    logic [KW-1:0] in_key, out_data;
`ifdef EP_XFER_CNT_EN
    logic [15:0]   xfer_cnt;
`endif
    logic          n_valid, n_ready, n_ovalid;
    logic [7:0]    n_r;
    logic [11:0]   n_data;

    int vectors = 0;
    int errors  = 0;
    logic [KW-1:0] exp_q[$];
    int            pos_q[$];
    int            exp_cnt = 0;

    expansion_xor_pipe #(.HALF_W(HW), .STAGES(ST)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_r_i(in_r), .in_key_i(in_key),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
`ifdef EP_XFER_CNT_EN
        , .xfer_cnt_o(xfer_cnt)
`endif
    );

    expansion_xor_pipe #(.HALF_W(8), .STAGES(1)) dut_n (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(1'b0),
        .in_valid_i(n_valid), .in_ready_o(n_ready),
        .in_r_i(n_r), .in_key_i(12'h000),
        .out_valid_o(n_ovalid), .out_ready_i(1'b1), .out_data_o(n_data)
`ifdef EP_XFER_CNT_EN
        , .xfer_cnt_o()
`endif
    );

    // Expansion straight from the rule: output bit p (1-based) of group (p-1)/6 takes R[4g+j].
    function automatic logic [47:0] e_ref(input logic [31:0] r, input int w);
        logic [47:0] e;
        int n, s;
        e = '0;
        n = 3 * w / 2;
        for (int p = 1; p <= n; p++) begin
            s = 4 * ((p - 1) / 6) + (p - 1) % 6;
            if (s == 0) s = w;
            else if (s == w + 1) s = 1;
            e[n - p] = r[w - s];
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the inputs already driven; compares, clocks, then advances the model.
    task automatic step(output bit dut_acc);
        bit mv, in_x, out_x;
        int lim, np;
        #1;
        mv = (exp_q.size() > 0) ? (pos_q[0] == ST - 1) : 1'b0;
        check("in_ready", {63'd0, in_ready}, {63'd0, !flush && (exp_q.size() < ST || out_ready)});
        check("out_valid", {63'd0, out_valid}, {63'd0, mv});
        if (mv) check("out_data", {16'd0, out_data}, {16'd0, exp_q[0]});
`ifdef EP_XFER_CNT_EN
        check("xfer_cnt", {48'd0, xfer_cnt}, 64'(exp_cnt));
`endif
        dut_acc = in_valid && in_ready;
        in_x    = in_valid && !flush && (exp_q.size() < ST || out_ready);
        out_x   = mv && out_ready && !flush;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            pos_q.delete();
        end else begin
            if (out_x) begin
                void'(exp_q.pop_front());
                void'(pos_q.pop_front());
                if (exp_cnt != 16'hFFFF) exp_cnt++;
            end
            lim = ST - 1;
            foreach (pos_q[i]) begin
                np = (pos_q[i] + 1 < lim) ? pos_q[i] + 1 : lim;
                pos_q[i] = np;
                lim = np - 1;
            end
            if (in_x) begin
                exp_q.push_back(e_ref(in_r, HW) ^ in_key);
                pos_q.push_back(0);
            end
        end
        #1;
    endtask

    initial begin
        bit a;
        int sent, cyc, fill;
        logic [31:0] words [8];
        logic [47:0] keys [8];
        logic [47:0] kk;
        int cnt_before;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_r = '0; in_key = '0; n_valid = 1'b0; n_r = '0;
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {16'd0, out_data}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        flush = 1'b1;
        #1;
        check("rst_flush_ready", {63'd0, in_ready}, 64'd0);
        flush = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Textbook DES round-1 vectors, latency one edge after acceptance with STAGES=2.
        in_r = 32'hF0AAF0AA; in_key = '0; out_ready = 1'b1; in_valid = 1'b1;
        step(a);
        in_valid = 1'b0;
        check("lat_not_yet", {63'd0, out_valid}, 64'd0);
        step(a);
        check("des_e_valid", {63'd0, out_valid}, 64'd1);
        check("des_e", {16'd0, out_data}, 64'h7A15557A1555);
        in_key = 48'h1B02EFFC7072; in_valid = 1'b1;
        step(a);
        in_valid = 1'b0;
        step(a);
        check("des_xor", {16'd0, out_data}, 64'h6117BA866527);

        // 8-bit wrap: 0x81 -> groups {R8,R1..R5}={110000}, {R4..R8,R1}={000011}.
        n_r = 8'h81; n_valid = 1'b1;
        step(a);
        check("wrap8_valid", {63'd0, n_ovalid}, 64'd1);
        check("wrap8", {52'd0, n_data}, 64'hC03);
        for (int i = 0; i < 4; i++) begin
            n_r = 8'($urandom);
            step(a);
            check("wrap8_rand", {52'd0, n_data}, {16'd0, e_ref({24'd0, n_r}, 8)});
        end
        n_valid = 1'b0;

        // Backpressure: 8 words against a stalled sink, then release.
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom;
            keys[i]  = {16'($urandom), 32'($urandom)};
        end
        out_ready = 1'b0; sent = 0; cyc = 0; fill = 0;
        while (sent < 8 && cyc < 200) begin
            in_valid = 1'b1; in_r = words[sent]; in_key = keys[sent];
            if (cyc == 6) begin
                check("fill_level", 64'(fill), 64'(ST));
                out_ready = 1'b1;
            end
            step(a);
            if (a) begin
                sent++;
                if (cyc < 6) fill++;
            end
            cyc++;
        end
        check("stream_timeout", 64'(sent), 64'd8);
        in_valid = 1'b0; cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            step(a);
            cyc++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);

        // Full pipeline, then flush together with a new input and an accepting sink.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_r = $urandom; in_key = {16'($urandom), 32'($urandom)};
            step(a);
        end
        cnt_before = exp_cnt;
        flush = 1'b1; out_ready = 1'b1;
        step(a);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
`ifdef EP_XFER_CNT_EN
        check("flush_cnt", {48'd0, xfer_cnt}, 64'(cnt_before));
`endif
        step(a);
        check("flush_nothing_taken", {63'd0, out_valid}, 64'd0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_r      = $urandom;
            in_key    = {16'($urandom), 32'($urandom)};
            step(a);
        end
        flush = 1'b0;

        // Asynchronous reset mid-stream.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_r = $urandom; in_key = {16'($urandom), 32'($urandom)};
            step(a);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_data", {16'd0, out_data}, 64'd0);
`ifdef EP_XFER_CNT_EN
        check("arst_cnt", {48'd0, xfer_cnt}, 64'd0);
`endif
        exp_q.delete(); pos_q.delete(); exp_cnt = 0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_r = $urandom; kk = {16'($urandom), 32'($urandom)}; in_key = kk; in_valid = 1'b1;
        step(a);
        in_valid = 1'b0;
        check("post_rst_lat0", {63'd0, out_valid}, 64'd0);
        step(a);
        check("post_rst_valid", {63'd0, out_valid}, 64'd1);
        check("post_rst_data", {16'd0, out_data}, {16'd0, e_ref(in_r, HW) ^ kk});
        step(a);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
